// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory between the CPU control path and a DMA/loader port, one access at a time.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of fixed CPU priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [1:0]       OWN_NONE = 2'b00;
    localparam logic [1:0]       OWN_CPU  = 2'b01;
    localparam logic [1:0]       OWN_DMA  = 2'b10;

    generate
        if ((MEM_LAT == 0) || (MEM_LAT > 15)) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              pick_dma;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_owner_q, last_owner_d;

    // On a tie the port not served last wins; a lone requester always wins.
    assign pick_dma = dma_req && (!cpu_req || (last_owner_q == OWN_CPU));
`else
    assign pick_dma = dma_req && !cpu_req;
`endif

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                owner_d = OWN_NONE;
                if (cpu_req || dma_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_INIT;
                    if (pick_dma) begin
                        owner_d     = OWN_DMA;
                        we_d        = dma_we;
                        mem_addr_d  = dma_addr;
                        mem_wdata_d = dma_wdata;
                    end else begin
                        owner_d     = OWN_CPU;
                        we_d        = cpu_we;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = owner_d;
`endif
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
                        else                    cpu_rdata_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        mem_en_d  = (state_d == ST_ACCESS);
        mem_we_d  = mem_en_d && (cnt_d == '0) && we_d;
        cpu_ack_d = (state_d == ST_RESP) && (owner_d == OWN_CPU);
        dma_ack_d = (state_d == ST_RESP) && (owner_d == OWN_DMA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_DMA;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_stall = cpu_req && !cpu_ack_q;
    assign dma_rdata = dma_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;

endmodule
